// File: rtl/pipe_ctrl_if.sv
// Control bus between the pipeline and pipe_ctrl: stall/redirect sources in,
// register enables and redirect target out.
interface pipe_ctrl_if;
    logic        icache_busy;
    logic        dcache_busy;
    logic        load_hazard;
    logic        mispredict;
    logic [31:0] mispredict_pc;
    logic        cache_stall;
    logic        flush;
    logic        pc_write_en;
    logic        if_id_write_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Pipeline side: raises stall/redirect requests, consumes enables.
    modport master (
        output icache_busy, dcache_busy, load_hazard, mispredict, mispredict_pc,
        input  cache_stall, flush, pc_write_en, if_id_write_en, redirect_valid, redirect_pc
    );

    // Controller side.
    modport slave (
        input  icache_busy, dcache_busy, load_hazard, mispredict, mispredict_pc,
        output cache_stall, flush, pc_write_en, if_id_write_en, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: arbitrates cache stalls, load-use stalls and
// mispredict redirects into PC / IF/ID enables, with saturating perf counters.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             perf_clear,
    pipe_ctrl_if.slave       bus,
    output logic [CNT_W-1:0] cnt_cache_stall,
    output logic [CNT_W-1:0] cnt_hazard,
    output logic [CNT_W-1:0] cnt_flush
);

    typedef enum logic [1:0] {RUN, PEND, SHADOW} state_t;

    state_t      state, next_state;
    logic [31:0] pend_pc, next_pend_pc;
    logic        busy;
    logic        hazard_stall;

    assign busy = bus.icache_busy | bus.dcache_busy;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state         = state;
        next_pend_pc       = pend_pc;
        bus.cache_stall    = 1'b0;
        bus.flush          = 1'b0;
        bus.pc_write_en    = 1'b0;
        bus.if_id_write_en = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = pend_pc;
        hazard_stall       = 1'b0;

        if (!rst) begin
            bus.redirect_pc = 32'h0;
        end else if (busy) begin
            bus.cache_stall = 1'b1;
            // A redirect seen during a stall is parked; the latest one wins.
            if (state != SHADOW && bus.mispredict) begin
                next_pend_pc = bus.mispredict_pc;
                next_state   = PEND;
            end
        end else begin
            case (state)
                RUN: begin
                    if (bus.mispredict) begin
                        bus.flush          = 1'b1;
                        bus.redirect_valid = 1'b1;
                        bus.redirect_pc    = bus.mispredict_pc;
                        bus.pc_write_en    = 1'b1;
                        bus.if_id_write_en = 1'b1;
                        next_state         = SHADOW;
                    end else begin
                        hazard_stall       = bus.load_hazard;
                        bus.pc_write_en    = !bus.load_hazard;
                        bus.if_id_write_en = !bus.load_hazard;
                    end
                end
                PEND: begin
                    bus.flush          = 1'b1;
                    bus.redirect_valid = 1'b1;
                    bus.pc_write_en    = 1'b1;
                    bus.if_id_write_en = 1'b1;
                    next_state         = SHADOW;
                end
                SHADOW: begin
                    // The instruction in MEM is wrong-path; its mispredict is ignored.
                    hazard_stall       = bus.load_hazard;
                    bus.pc_write_en    = !bus.load_hazard;
                    bus.if_id_write_en = !bus.load_hazard;
                    next_state         = RUN;
                end
                default: next_state = RUN;
            endcase
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic ev);
        return (ev && cnt != '1) ? cnt + CNT_W'(1) : cnt;
    endfunction

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= RUN;
            pend_pc         <= 32'h0;
            cnt_cache_stall <= '0;
            cnt_hazard      <= '0;
            cnt_flush       <= '0;
        end else begin
            state   <= next_state;
            pend_pc <= next_pend_pc;
            if (perf_clear) begin
                cnt_cache_stall <= '0;
                cnt_hazard      <= '0;
                cnt_flush       <= '0;
            end else begin
                cnt_cache_stall <= sat_inc(cnt_cache_stall, bus.cache_stall);
                cnt_hazard      <= sat_inc(cnt_hazard, hazard_stall);
                cnt_flush       <= sat_inc(cnt_flush, bus.flush);
            end
        end
    end

endmodule
